// File: rtl/jtpopeye_busarb_if.sv
// Bundle of CPU, RAM and video-DMA signals around the bus arbiter.
// slave = arbiter side, master = the surrounding CPU/RAM/video logic.
interface jtpopeye_busarb_if #(parameter int AW = 11);
  logic          cpu_cen;
  logic          cpu_busy;
  logic          busrq_n;
  logic          busak_n;
  logic          cpu_hold;
  logic [9:0]    AD_DMA;
  logic          dma_cs;
  logic [7:0]    DD_DMA;
  logic [AW-1:0] cpu_addr;
  logic          cpu_we;
  logic [7:0]    cpu_din;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_din;
  logic [7:0]    ram_dout;
  logic [9:0]    dma_cnt;

  modport slave (
    input  cpu_cen, cpu_busy, busrq_n, AD_DMA, dma_cs, cpu_addr, cpu_we, cpu_din, ram_dout,
    output busak_n, cpu_hold, DD_DMA, ram_addr, ram_we, ram_din, dma_cnt
  );
  modport master (
    output cpu_cen, cpu_busy, busrq_n, AD_DMA, dma_cs, cpu_addr, cpu_we, cpu_din, ram_dout,
    input  busak_n, cpu_hold, DD_DMA, ram_addr, ram_we, ram_din, dma_cnt
  );
endinterface

// File: rtl/jtpopeye_busarb.sv
// Video DMA bus responder: stalls the Z80 at a machine-cycle gap, grants the
// bus with busak_n and steers main RAM to the DMA engine while granted.
module jtpopeye_busarb #(
  parameter int            AW       = 11,
  parameter logic [AW-1:0] DMA_BASE = 11'h400
)(
  input  logic clk,
  input  logic rst,
  jtpopeye_busarb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_GAP, GRANT, RELEASE} state_t;

  state_t        state, state_nx;
  logic          busrq_r;
  logic          grant_go, release_go;
  logic          dma_on;
  logic [AW-1:0] dma_addr;

  // RAM ownership follows the registered acknowledge, never the raw state
  assign dma_on       = ~bus.busak_n;
  assign dma_addr     = DMA_BASE + AW'(bus.AD_DMA);
  assign bus.ram_addr = dma_on ? dma_addr : bus.cpu_addr;
  assign bus.ram_we   = ~dma_on & bus.cpu_we;
  assign bus.ram_din  = bus.cpu_din;

  always_comb begin
    state_nx   = state;
    grant_go   = 1'b0;
    release_go = 1'b0;
    case (state)
      IDLE:     if (bus.cpu_cen && !busrq_r) state_nx = WAIT_GAP;
      WAIT_GAP: if (bus.cpu_cen) begin
                  if (busrq_r) state_nx = IDLE;
                  else if (!bus.cpu_busy) begin
                    state_nx = GRANT;
                    grant_go = 1'b1;
                  end
                end
      GRANT:    if (bus.cpu_cen && busrq_r) begin
                  state_nx   = RELEASE;
                  release_go = 1'b1;
                end
      RELEASE:  state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busrq_r      <= 1'b1;
      bus.busak_n  <= 1'b1;
      bus.cpu_hold <= 1'b0;
      bus.DD_DMA   <= 8'd0;
      bus.dma_cnt  <= 10'd0;
    end else begin
      state   <= state_nx;
      busrq_r <= bus.busrq_n;
      if (grant_go)            bus.cpu_hold <= 1'b1;
      else if (state == RELEASE) bus.cpu_hold <= 1'b0;
      // ack lags the hold by one clk on entry, drops on the release edge itself
      bus.busak_n <= ~(state == GRANT && !release_go);
      if (dma_on && bus.dma_cs) bus.DD_DMA <= bus.ram_dout;
      if (grant_go)                  bus.dma_cnt <= 10'd0;
      else if (dma_on && bus.dma_cs) bus.dma_cnt <= bus.dma_cnt + 10'd1;
    end
  end
endmodule

// File: tb/tb_jtpopeye_busarb.sv
// Random-stimulus bench: two arbiters (DMA_BASE 0x400 and 0x700) on private
// RAMs, compared every clk against a behavioural model of the grant protocol.
module tb_jtpopeye_busarb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cen, busy, rq_n, cs, we;
  logic [9:0]  ad;
  logic [10:0] addr;
  logic [7:0]  din;

  jtpopeye_busarb_if #(.AW(11)) bus0();
  jtpopeye_busarb_if #(.AW(11)) bus1();

  jtpopeye_busarb #(.AW(11), .DMA_BASE(11'h400)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  jtpopeye_busarb #(.AW(11), .DMA_BASE(11'h700)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  assign {bus0.cpu_cen, bus1.cpu_cen}   = {cen, cen};
  assign {bus0.cpu_busy, bus1.cpu_busy} = {busy, busy};
  assign {bus0.busrq_n, bus1.busrq_n}   = {rq_n, rq_n};
  assign {bus0.dma_cs, bus1.dma_cs}     = {cs, cs};
  assign {bus0.cpu_we, bus1.cpu_we}     = {we, we};
  assign bus0.AD_DMA   = ad;
  assign bus1.AD_DMA   = ad;
  assign bus0.cpu_addr = addr;
  assign bus1.cpu_addr = addr;
  assign bus0.cpu_din  = din;
  assign bus1.cpu_din  = din;

  logic [7:0] ram0 [2048];
  logic [7:0] ram1 [2048];
  assign bus0.ram_dout = ram0[bus0.ram_addr];
  assign bus1.ram_dout = ram1[bus1.ram_addr];
  always @(posedge clk) begin
    if (bus0.ram_we) ram0[bus0.ram_addr] <= bus0.ram_din;
    if (bus1.ram_we) ram1[bus1.ram_addr] <= bus1.ram_din;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: what the CPU and DMA engine should observe
  logic [7:0] mem [2048];
  bit         m_rq, m_armed, m_stalled, m_owned, m_wind;
  logic [7:0] m_dd0, m_dd1;
  int         m_cnt;

  function automatic logic [10:0] dma_at(input int base, input logic [9:0] a);
    return 11'((base + int'(a)) % 2048);
  endfunction

  task automatic model_step();
    if (m_owned && cs && !rst) begin
      m_dd0 = mem[dma_at(32'h400, ad)];
      m_dd1 = mem[dma_at(32'h700, ad)];
      m_cnt = (m_cnt + 1) % 1024;
    end
    if (!m_owned && we) mem[addr] = din;
    if (rst) begin
      m_rq = 1; m_armed = 0; m_stalled = 0; m_owned = 0; m_wind = 0;
      m_dd0 = 0; m_dd1 = 0; m_cnt = 0;
      return;
    end
    if (m_wind) begin
      m_stalled = 0;
      m_wind    = 0;
    end else if (m_stalled) begin
      if (cen && m_rq) begin
        m_owned = 0;
        m_wind  = 1;
      end else m_owned = 1;
    end else if (cen) begin
      if (m_armed) begin
        if (m_rq) m_armed = 0;
        else if (!busy) begin
          m_armed = 0; m_stalled = 1; m_cnt = 0;
        end
      end else if (!m_rq) m_armed = 1;
    end
    m_rq = rq_n;
  endtask

  // Inputs already applied just after a negedge; check, advance model, wait
  task automatic cyc();
    #1;
    chk("busak_n",  32'(bus0.busak_n),  32'(!m_owned));
    chk("cpu_hold", 32'(bus0.cpu_hold), 32'(m_stalled));
    chk("dd_dma",   32'(bus0.DD_DMA),   32'(m_dd0));
    chk("dma_cnt",  32'(bus0.dma_cnt),  32'(m_cnt));
    chk("ram_addr", 32'(bus0.ram_addr), 32'(m_owned ? dma_at(32'h400, ad) : addr));
    chk("ram_we",   32'(bus0.ram_we),   32'(!m_owned && we));
    chk("ram_din",  32'(bus0.ram_din),  32'(din));
    chk("busak_n_b700",  32'(bus1.busak_n),  32'(!m_owned));
    chk("ram_addr_b700", 32'(bus1.ram_addr), 32'(m_owned ? dma_at(32'h700, ad) : addr));
    chk("dd_dma_b700",   32'(bus1.DD_DMA),   32'(m_dd1));
    model_step();
    @(negedge clk);
  endtask

  task automatic rand_in(input int mode);
    cen  = ($urandom % 3) != 0;
    busy = ($urandom % 4) != 0;
    if (($urandom % (mode == 1 ? 3 : 25)) == 0) rq_n = ~rq_n;
    cs   = $urandom % 2;
    case ($urandom % 4)
      0:       ad = 10'h3FF;
      1:       ad = 10'h100;
      default: ad = 10'($urandom);
    endcase
    addr = ($urandom % 3 == 0) ? 11'h500 : 11'($urandom);
    we   = ($urandom % 4) == 0;
    din  = 8'($urandom);
    rst  = ($urandom % 200) == 0;
  endtask

  initial begin
    rst = 1; cen = 0; busy = 1; rq_n = 0; cs = 0; we = 0; ad = 0; addr = 0; din = 0;
    repeat (2) @(negedge clk);
    m_rq = 1; m_armed = 0; m_stalled = 0; m_owned = 0; m_wind = 0;
    m_dd0 = 0; m_dd1 = 0; m_cnt = 0;
    // Preload every RAM word through the CPU path while reset holds off DMA
    for (int i = 0; i < 2048; i++) begin
      cen = 1; we = 1; addr = 11'(i);
      din = (i == 32'h500) ? 8'hA5 : 8'($urandom);
      cyc();
    end
    rst = 0; we = 0; busy = 1;
    // Busy CPU for several cen, then a gap opens
    for (int i = 0; i < 6; i++) begin cen = 1; cyc(); cen = 0; cyc(); end
    busy = 0; cen = 1; cyc();
    cen = 0; cyc(); cyc();
    // Read 0x500 through AD_DMA=0x100, try a blocked CPU write, then 1100 strobes
    ad = 10'h100; cs = 1; cyc();
    cs = 0; we = 1; addr = 11'h500; din = 8'h5A; cyc();
    we = 0; cs = 1;
    for (int i = 0; i < 1100; i++) begin
      ad = (i % 5 == 0) ? 10'h3FF : 10'($urandom);
      cen = $urandom % 2;
      cyc();
    end
    // Release, then the same write must land
    cs = 0; rq_n = 1; cen = 1; cyc(); cyc(); cyc();
    we = 1; addr = 11'h500; din = 8'h5A; cyc();
    we = 0;
    for (int seg = 0; seg < 8; seg++)
      for (int i = 0; i < 300; i++) begin
        rand_in(seg % 2);
        cyc();
      end
    rst = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
